// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU: computes the MIPS ALU operation selected by the
// ALU control decoder and registers result, zero flag, valid and illegal-op strobe.
module alu_exec_stage #(
    parameter int NB_DATA   = 32,
    parameter int ALU_OP    = 4,
    parameter int NB_SHAMT  = 5,
    parameter int NB_ERRCNT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [ALU_OP-1:0]    i_alu_op,
    input  logic                 i_shamt,
    input  logic [NB_SHAMT-1:0]  i_shamt_val,
    input  logic [NB_DATA-1:0]   i_data_a,
    input  logic [NB_DATA-1:0]   i_data_b,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_zero,
    output logic                 o_valid,
    output logic                 o_illegal_op,
    output logic [NB_ERRCNT-1:0] o_err_count
);

    localparam logic [ALU_OP-1:0] OP_ADD = 4'b0000;
    localparam logic [ALU_OP-1:0] OP_SUB = 4'b0001;
    localparam logic [ALU_OP-1:0] OP_AND = 4'b0010;
    localparam logic [ALU_OP-1:0] OP_OR  = 4'b0011;
    localparam logic [ALU_OP-1:0] OP_NOR = 4'b0100;
    localparam logic [ALU_OP-1:0] OP_XOR = 4'b0101;
    localparam logic [ALU_OP-1:0] OP_SLT = 4'b0111;
    localparam logic [ALU_OP-1:0] OP_SLL = 4'b1000;
    localparam logic [ALU_OP-1:0] OP_SRL = 4'b1001;
    localparam logic [ALU_OP-1:0] OP_SRA = 4'b1011;

    logic [NB_SHAMT-1:0]  sa;
    logic [NB_DATA-1:0]   alu_res;
    logic                 alu_illegal;

    logic [NB_DATA-1:0]   result_d,  result_q;
    logic                 zero_d,    zero_q;
    logic                 valid_d,   valid_q;
    logic                 illegal_d, illegal_q;
    logic [NB_ERRCNT-1:0] err_d,     err_q;

    // Any code not decoded below is an error/undefined code from ALU control.
    always_comb begin
        sa          = i_shamt ? i_shamt_val : i_data_a[NB_SHAMT-1:0];
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (i_alu_op)
            OP_ADD:  alu_res = i_data_a + i_data_b;
            OP_SUB:  alu_res = i_data_a - i_data_b;
            OP_AND:  alu_res = i_data_a & i_data_b;
            OP_OR:   alu_res = i_data_a | i_data_b;
            OP_NOR:  alu_res = ~(i_data_a | i_data_b);
            OP_XOR:  alu_res = i_data_a ^ i_data_b;
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLL:  alu_res = i_data_b << sa;
            OP_SRL:  alu_res = i_data_b >> sa;
            OP_SRA:  alu_res = $signed(i_data_b) >>> sa;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Update priority: flush, then stall, then load/idle.
    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        if (i_flush) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!i_stall) begin
            if (i_valid) begin
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                valid_d   = 1'b1;
                illegal_d = alu_illegal;
                if (alu_illegal && (err_q != '1)) begin
                    err_d = err_q + NB_ERRCNT'(1);
                end
            end else begin
                valid_d   = 1'b0;
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign o_result     = result_q;
    assign o_zero       = zero_q;
    assign o_valid      = valid_q;
    assign o_illegal_op = illegal_q;
    assign o_err_count  = err_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: expectations are queued when an op is
// issued and popped when the registered output appears one cycle later.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, stall, flush, shamt_sel;
    logic [3:0]  op;
    logic [4:0]  shamt_val;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        zero, valid_out, illegal;
    logic [7:0]  err_count;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (valid_in),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_alu_op     (op),
        .i_shamt      (shamt_sel),
        .i_shamt_val  (shamt_val),
        .i_data_a     (a),
        .i_data_b     (b),
        .o_result     (result),
        .o_zero       (zero),
        .o_valid      (valid_out),
        .o_illegal_op (illegal),
        .o_err_count  (err_count)
    );

    // Independent reference for random legal ops
    function automatic logic [31:0] golden(input logic [3:0] o, input logic s,
                                           input logic [4:0] sv, input logic [31:0] x,
                                           input logic [31:0] y);
        logic [4:0] amt;
        logic [63:0] ext;
        amt = s ? sv : x[4:0];
        ext = {{32{y[31]}}, y} >> amt;
        case (o)
            4'd0:  return x + y;
            4'd1:  return x + (~y + 32'd1);
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return ~x & ~y;
            4'd5:  return (x | y) & ~(x & y);
            4'd7:  return ((x[31] & ~y[31]) || ((x[31] == y[31]) && (x < y))) ? 32'd1 : 32'd0;
            4'd8:  return y << amt;
            4'd9:  return y >> amt;
            4'd11: return ext[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic s, input logic [4:0] sv,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res, input logic exp_ill);
        exp_t n;
        valid_in  = 1'b1;
        op        = o;
        shamt_sel = s;
        shamt_val = sv;
        a         = x;
        b         = y;
        n.res     = exp_res;
        n.ill     = exp_ill;
        sb.push_back(n);
        if (exp_ill && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 0; stall = 0; flush = 0; op = 0;
        shamt_sel = 0; shamt_val = 0; a = 0; b = 0;
        #2;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b0 ||
            illegal !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_init: got res=%h z=%b v=%b ill=%b cnt=%0d want 0/1/0/0/0",
                     result, zero, valid_out, illegal, err_count);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_arith();
        logic [31:0] want[3];
        logic        wz[3];
        want = '{32'h8000_0000, 32'd0, 32'd1};
        wz   = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: issue(4'd0, 0, 0, 32'h7FFF_FFFF, 32'd1, want[0], 0);
                1: issue(4'd1, 0, 0, 32'd5, 32'd5, want[1], 0);
                default: issue(4'd7, 0, 0, 32'hFFFF_FFFF, 32'd1, want[2], 0);
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if (result !== e.res || zero !== wz[i] || valid_out !== 1'b1 || illegal !== e.ill) begin
                errors++;
                $display("[TB] FAIL arith_%0d: got res=%h z=%b v=%b ill=%b want res=%h z=%b v=1 ill=%b",
                         i, result, zero, valid_out, illegal, e.res, wz[i], e.ill);
            end
        end
    endtask

    task automatic test_shifts();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: issue(4'b1011, 1, 5'd4, 32'd0, 32'h8000_0000, 32'hF800_0000, 0);
                1: issue(4'b1001, 0, 5'd17, 32'hFFFF_FFE4, 32'h8000_0000, 32'h0800_0000, 0);
                default: issue(4'b1000, 1, 5'd31, 32'd0, 32'd1, 32'h8000_0000, 0);
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if (result !== e.res || valid_out !== 1'b1 || zero !== 1'b0) begin
                errors++;
                $display("[TB] FAIL shift_%0d: got res=%h v=%b z=%b want res=%h v=1 z=0",
                         i, result, valid_out, zero, e.res);
            end
        end
    endtask

    task automatic test_illegal();
        issue(4'b1111, 0, 0, 32'h1234, 32'h5678, 32'd0, 1);
        step();
        e = sb.pop_front();
        checks++;
        if (result !== e.res || illegal !== 1'b1 || valid_out !== 1'b1 || zero !== 1'b1 ||
            err_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL illegal_1111: got res=%h ill=%b v=%b z=%b cnt=%0d want 0/1/1/1/1",
                     result, illegal, valid_out, zero, err_count);
        end
        issue(4'b0110, 0, 0, 32'hAAAA, 32'h5555, 32'd0, 1);
        step();
        e = sb.pop_front();
        checks++;
        if (result !== e.res || illegal !== 1'b1 || valid_out !== 1'b1 || err_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL illegal_0110: got res=%h ill=%b v=%b cnt=%0d want 0/1/1/2",
                     result, illegal, valid_out, err_count);
        end
        valid_in = 1'b0;
        step();
        checks++;
        if (valid_out !== 1'b0 || illegal !== 1'b0 || err_count !== 8'd2 || zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_idle: got v=%b ill=%b cnt=%0d z=%b want 0/0/2/1",
                     valid_out, illegal, err_count, zero);
        end
    endtask

    task automatic test_stall_flush();
        issue(4'd0, 0, 0, 32'd1, 32'd2, 32'd3, 0);
        step();
        e = sb.pop_front();
        checks++;
        if (result !== e.res || valid_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_load: got res=%h v=%b want res=%h v=1", result, valid_out, e.res);
        end
        stall = 1'b1; valid_in = 1'b1; op = 4'd1; a = 32'd10; b = 32'd10;
        for (int i = 0; i < 3; i++) begin
            a = a + 32'd7;
            step();
            checks++;
            if (result !== 32'd3 || valid_out !== 1'b1 || zero !== 1'b0 || illegal !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got res=%h v=%b z=%b ill=%b want 3/1/0/0",
                         i, result, valid_out, zero, illegal);
            end
        end
        stall = 1'b0;
        issue(4'b1101, 0, 0, 32'd9, 32'd9, 32'd0, 1);
        step();
        e = sb.pop_front();
        stall = 1'b1; op = 4'd0; a = 32'd4; b = 32'd4;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (illegal !== 1'b1 || valid_out !== 1'b1 || result !== e.res ||
                err_count !== 8'(exp_cnt)) begin
                errors++;
                $display("[TB] FAIL stall_pulse_%0d: got ill=%b v=%b res=%h cnt=%0d want 1/1/%h/%0d",
                         i, illegal, valid_out, result, err_count, e.res, exp_cnt);
            end
        end
        flush = 1'b1; op = 4'b1110;
        step();
        checks++;
        if (valid_out !== 1'b0 || illegal !== 1'b0 || err_count !== 8'(exp_cnt) ||
            result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_stall: got v=%b ill=%b cnt=%0d res=%h z=%b want 0/0/%0d/0/1",
                     valid_out, illegal, err_count, result, zero, exp_cnt);
        end
        flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] legal[10];
        logic [3:0] o;
        logic       s;
        logic [4:0] sv;
        logic [31:0] x, y;
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd11};
        for (int i = 0; i < 10; i++) begin
            o  = legal[$urandom_range(0, 9)];
            s  = 1'($urandom_range(0, 1));
            sv = 5'($urandom);
            x  = $urandom;
            y  = $urandom;
            if (i == 0) begin o = 4'd11; y = 32'h9000_0001; end
            issue(o, s, sv, x, y, golden(o, s, sv, x, y), 0);
            step();
            e = sb.pop_front();
            checks++;
            if (result !== e.res || valid_out !== 1'b1 || zero !== (e.res == 32'd0) ||
                illegal !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_%0d op=%h: got res=%h v=%b z=%b want res=%h v=1",
                         i, o, result, valid_out, zero, e.res);
            end
        end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            issue(4'b1100 + 4'(i % 4), 0, 0, 32'(i), 32'd1, 32'd0, 1);
            step();
            e = sb.pop_front();
            if (i == 100) begin
                checks++;
                if (err_count !== 8'(exp_cnt) || illegal !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL sat_mid: got cnt=%0d ill=%b want %0d/1",
                             err_count, illegal, exp_cnt);
                end
            end
        end
        valid_in = 1'b0;
        step();
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_final: got cnt=%0d want 255", err_count);
        end
    endtask

    task automatic test_reset_midstream();
        issue(4'd2, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0);
        step();
        e = sb.pop_front();
        checks++;
        if (valid_out !== 1'b1 || result !== e.res) begin
            errors++;
            $display("[TB] FAIL rst_pre: got v=%b res=%h want 1/%h", valid_out, result, e.res);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b0 ||
            illegal !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid: got res=%h z=%b v=%b ill=%b cnt=%0d want 0/1/0/0/0",
                     result, zero, valid_out, illegal, err_count);
        end
        valid_in = 1'b0;
        exp_cnt = 0;
        #1 rst = 1'b0;
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_discard: got v=%b want 0", valid_out);
        end
        issue(4'd0, 0, 0, 32'd2, 32'd2, 32'd4, 0);
        step();
        e = sb.pop_front();
        checks++;
        if (valid_out !== 1'b1 || result !== e.res || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_first: got v=%b res=%h cnt=%0d want 1/%h/0",
                     valid_out, result, err_count, e.res);
        end
        valid_in = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shifts();
        test_illegal();
        test_stall_flush();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute-stage ALU for the MIPS datapath. It consumes the 4-bit ALU operation code and shamt-select flag produced by the ALU control decoder, together with the two operands and the instruction shamt field. It produces a registered result, zero flag and valid strobe for the EX/MEM boundary. It also detects the decoder's error and undefined codes, and keeps a saturating count of them.

## Interface
- NB_DATA, 32, operand/result width
- ALU_OP, 4, width of operation code from ALU control
- NB_SHAMT, 5, width of shift amount
- NB_ERRCNT, 8, width of illegal-op counter
- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_valid  input  1  operands/op valid this cycle
- i_stall  input  1  hold pipeline register (hazard stall)
- i_flush  input  1  kill instruction entering register
- i_alu_op  input  ALU_OP  operation code from ALU control
- i_shamt  input  1  1: shift amount from i_shamt_val; 0: from i_data_a[4:0]
- i_shamt_val  input  NB_SHAMT  instruction shamt field
- i_data_a  input  NB_DATA  operand A (rs)
- i_data_b  input  NB_DATA  operand B (rt or immediate)
- o_result  output  NB_DATA  registered result
- o_zero  output  1  registered, o_result == 0
- o_valid  output  1  registered result valid
- o_illegal_op  output  1  one-cycle pulse: accepted op was illegal
- o_err_count  output  NB_ERRCNT  saturating count of accepted illegal ops

## Operation
- Op decode:
  - 0000 ADD: A+B, wrap mod 2^32, no overflow trap
  - 0001 SUB: A−B
  - 0010 AND
  - 0011 OR
  - 0100 NOR: ~(A|B)
  - 0101 XOR
  - 0111 SLT: signed A<B gives 1, else 0
  - 1000 SLL: B << sa
  - 1001 SRL: B >> sa, zero fill
  - 1011 SRA: B >> sa, sign fill
- Shift amount sa: i_shamt ? i_shamt_val : i_data_a[4:0]. Upper bits of A are ignored.
- Illegal codes: 0110, 1010, 1100, 1101 (−3), 1110 (−2), 1111 (−1).
  - Computed result is 0.
  - o_illegal_op=1 on the output cycle.
  - Counter increments.
- Register update priority per cycle: flush > stall > load.
  - Flush: o_valid←0, o_illegal_op←0. o_result/o_zero hold. Counter unchanged.
  - Stall (no flush): all outputs and counter hold. Inputs are ignored.
  - Load (i_valid=1): o_result, o_zero, o_illegal_op update; o_valid←1. Counter +1 if illegal and below max.
  - Idle (i_valid=0): o_valid←0, o_illegal_op←0. o_result/o_zero hold.
- o_err_count saturates at 2^NB_ERRCNT−1 (255). It clears only on reset.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Throughput 1 op/cycle when not stalled.
- Reset values (asynchronous, immediate):
  - o_result=0, o_zero=1, o_valid=0, o_illegal_op=0, o_err_count=0.
- Reset asserted mid-operation discards the pending result. First valid output comes 1 cycle after the first accepted i_valid following deassertion.
- o_illegal_op is high only while o_valid is high. A stall holds both, so the pulse lasts as long as the stall.
- Flush and stall together: flush wins, and o_valid drops at the next edge.
- o_zero is derived from the next-state result, so it is always coherent with o_result.

## Test plan
- Reset: assert i_reset mid-stream with o_valid=1 -> outputs immediately 0 / zero=1 / valid=0 / count=0.
- Arithmetic: ADD 0x7FFFFFFF+1 -> 0x80000000, valid next cycle. SUB 5−5 -> 0, zero=1. SLT A=0xFFFFFFFF, B=1 -> 1.
- Shifts:
  - SRA B=0x80000000, i_shamt=1, sa=4 -> 0xF8000000.
  - SRL with i_shamt=0, A=0xFFFFFFE4 (sa=4) -> 0x08000000.
  - SLL sa=31, B=1 -> 0x80000000.
- Illegal: op 1111 then 0110 back-to-back -> result 0, o_illegal_op=1 both cycles, count=2. Issue 300 illegal ops -> count=255.
- Stall/flush:
  - Stall 3 cycles with new inputs present -> outputs frozen.
  - Flush together with stall and an illegal op -> valid=0, count unchanged.
- Back-to-back mix of 10 random legal ops -> results match the golden model at 1-cycle latency, valid continuous.
